// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback and drives ALU and datapath selects.
// Optional performance counters are enabled with `define PERF_COUNTER_EN.

`ifndef FUNC_ADD
`define FUNC_ADD  4'd0
`define FUNC_SUB  4'd1
`define FUNC_SLL  4'd2
`define FUNC_XOR  4'd3
`define FUNC_SRL  4'd4
`define FUNC_OR   4'd5
`define FUNC_AND  4'd6
`define FUNC_BEQ  4'd7
`define FUNC_BNE  4'd8
`define FUNC_BLT  4'd9
`define FUNC_BGE  4'd10
`define FUNC_JALR 4'd11
`endif

module multicycle_control_unit #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic                 funct7_5,
    input  logic                 alu_bcond,
    input  logic                 mem_ready,
    input  logic                 halt_req,
    output logic [3:0]           alu_op,
    output logic [1:0]           alu_src_a,
    output logic                 alu_src_b,
    output logic                 aluout_write,
    output logic                 ir_write,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 i_or_d,
    output logic                 reg_write,
    output logic [1:0]           wb_sel,
    output logic                 pc_write,
    output logic [1:0]           pc_src,
    output logic                 is_halted,
    output logic [2:0]           state,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic [CNT_WIDTH-1:0] instr_count
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    state_t r_state;
    state_t w_nextState;
    logic   w_isLoad;
    logic   w_isJump;

    function automatic logic [3:0] aluFunc(input logic [2:0] f3, input logic useSub);
        case (f3)
            3'b000:  aluFunc = useSub ? `FUNC_SUB : `FUNC_ADD;
            3'b001:  aluFunc = `FUNC_SLL;
            3'b100:  aluFunc = `FUNC_XOR;
            3'b101:  aluFunc = `FUNC_SRL;
            3'b110:  aluFunc = `FUNC_OR;
            3'b111:  aluFunc = `FUNC_AND;
            default: aluFunc = `FUNC_ADD;
        endcase
    endfunction

    function automatic logic [3:0] branchFunc(input logic [2:0] f3);
        case (f3)
            3'b001:         branchFunc = `FUNC_BNE;
            3'b100, 3'b110: branchFunc = `FUNC_BLT;
            3'b101, 3'b111: branchFunc = `FUNC_BGE;
            default:        branchFunc = `FUNC_BEQ;
        endcase
    endfunction

    assign w_isLoad = (opcode == OP_LOAD);
    assign w_isJump = (opcode == OP_JAL) || (opcode == OP_JALR);
    assign state    = r_state;

    // Outputs and next state; everything is forced low while reset is asserted.
    always_comb begin
        w_nextState  = r_state;
        alu_op       = `FUNC_ADD;
        alu_src_a    = 2'd0;
        alu_src_b    = 1'b0;
        aluout_write = 1'b0;
        ir_write     = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        i_or_d       = 1'b0;
        reg_write    = 1'b0;
        wb_sel       = 2'd0;
        pc_write     = 1'b0;
        pc_src       = 2'd0;
        is_halted    = 1'b0;
        if (!reset) begin
            case (r_state)
                S_IF: begin
                    mem_read = 1'b1;
                    ir_write = mem_ready;
                    if (mem_ready) w_nextState = S_ID;
                end
                S_ID: begin
                    alu_src_b    = 1'b1;
                    aluout_write = 1'b1;
                    w_nextState  = S_EX;
                end
                S_EX: begin
                    w_nextState = S_WB;
                    case (opcode)
                        OP_R: begin
                            alu_src_a    = 2'd1;
                            alu_op       = aluFunc(funct3, funct7_5);
                            aluout_write = 1'b1;
                        end
                        OP_I: begin
                            alu_src_a    = 2'd1;
                            alu_src_b    = 1'b1;
                            alu_op       = aluFunc(funct3, 1'b0);
                            aluout_write = 1'b1;
                        end
                        OP_LOAD, OP_STORE: begin
                            alu_src_a    = 2'd1;
                            alu_src_b    = 1'b1;
                            aluout_write = 1'b1;
                            w_nextState  = S_MEM;
                        end
                        // ALUOut still holds the ID-computed target, so it must not be overwritten.
                        OP_BRANCH: begin
                            alu_src_a   = 2'd1;
                            alu_op      = branchFunc(funct3);
                            pc_write    = 1'b1;
                            pc_src      = alu_bcond ? 2'd1 : 2'd0;
                            w_nextState = S_IF;
                        end
                        OP_JAL: begin
                        end
                        OP_JALR: begin
                            alu_src_a    = 2'd1;
                            alu_src_b    = 1'b1;
                            alu_op       = `FUNC_JALR;
                            aluout_write = 1'b1;
                        end
                        OP_LUI: begin
                            alu_src_a    = 2'd2;
                            alu_src_b    = 1'b1;
                            aluout_write = 1'b1;
                        end
                        OP_AUIPC: begin
                            alu_src_b    = 1'b1;
                            aluout_write = 1'b1;
                        end
                        OP_SYSTEM: begin
                            if (halt_req) begin
                                w_nextState = S_HALT;
                            end else begin
                                pc_write    = 1'b1;
                                w_nextState = S_IF;
                            end
                        end
                        default: begin
                            pc_write    = 1'b1;
                            w_nextState = S_IF;
                        end
                    endcase
                end
                S_MEM: begin
                    i_or_d    = 1'b1;
                    mem_read  = w_isLoad;
                    mem_write = !w_isLoad;
                    if (mem_ready) begin
                        if (w_isLoad) begin
                            w_nextState = S_WB;
                        end else begin
                            pc_write    = 1'b1;
                            w_nextState = S_IF;
                        end
                    end
                end
                S_WB: begin
                    reg_write   = 1'b1;
                    pc_write    = 1'b1;
                    wb_sel      = w_isLoad ? 2'd1 : (w_isJump ? 2'd2 : 2'd0);
                    pc_src      = w_isJump ? 2'd1 : 2'd0;
                    w_nextState = S_IF;
                end
                S_HALT: begin
                    is_halted   = 1'b1;
                    w_nextState = S_HALT;
                end
                default: w_nextState = S_IF;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IF;
        else       r_state <= w_nextState;
    end

`ifdef PERF_COUNTER_EN
    logic                 w_retire;
    logic [CNT_WIDTH-1:0] r_cycleCount;
    logic [CNT_WIDTH-1:0] r_instrCount;

    // The halting ECALL also counts as a retired instruction even though IF is never re-entered.
    assign w_retire = ((w_nextState == S_IF) && (r_state != S_IF)) ||
                      ((r_state == S_EX) && (w_nextState == S_HALT));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cycleCount <= '0;
            r_instrCount <= '0;
        end else begin
            if (r_state != S_HALT) r_cycleCount <= r_cycleCount + CNT_WIDTH'(1);
            if (w_retire)          r_instrCount <= r_instrCount + CNT_WIDTH'(1);
        end
    end

    assign cycle_count = r_cycleCount;
    assign instr_count = r_instrCount;
`else
    assign cycle_count = {CNT_WIDTH{1'b0}};
    assign instr_count = {CNT_WIDTH{1'b0}};
`endif

endmodule
